// File: rtl/prog_rom_monitor_if.sv
// Instruction bus between a Harvard CPU fetch port and the program ROM.
//   instr_address   CPU fetch byte address
//   instr_readdata  fetched instruction word (combinational)
// master: CPU side (drives address); slave: ROM side (returns data).
interface prog_rom_monitor_if;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;

    modport master (output instr_address, input instr_readdata);
    modport slave  (input instr_address, output instr_readdata);
endinterface

// File: rtl/prog_rom_monitor.sv
// Instruction ROM plus run monitor for Harvard CPU benches.
// Programs are written through the load port while idle or done, fetches are served
// combinationally, and a run FSM detects the jump to HALT_ADDR, waits SETTLE enabled
// cycles, then compares register_v0 against expected_v0.
// Ports:
//   clk, reset (async, active-low)  clock and reset; ROM contents survive reset
//   clk_enable                      FSM and counters advance only when high
//   start                           begin a run from IDLE or DONE
//   load_en/load_addr/load_data     ROM write port
//   expected_v0, register_v0        result comparison at end of settle window
//   instr_bus (slave)               CPU instruction fetch bus
//   done, pass, fail_code           run result (fail: 1 mismatch, 2 timeout, 3 fetch fault)
//   cycle_count                     enabled RUN cycles before halt or failure
module prog_rom_monitor #(
    parameter logic [31:0] ADDR_BASE = 32'hBFC00000,
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] HALT_ADDR = 32'h00000000,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned SETTLE    = 2,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic                     start,
    input  logic                     load_en,
    input  logic [AW-1:0]            load_addr,
    input  logic [31:0]              load_data,
    input  logic [31:0]              expected_v0,
    input  logic [31:0]              register_v0,
    prog_rom_monitor_if.slave        instr_bus,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               fail_code,
    output logic [31:0]              cycle_count
);

    typedef enum logic [1:0] {StIdle, StRun, StSettle, StDone} state_e;

    localparam logic [1:0]  FailNone     = 2'd0;
    localparam logic [1:0]  FailMismatch = 2'd1;
    localparam logic [1:0]  FailTimeout  = 2'd2;
    localparam logic [1:0]  FailFetch    = 2'd3;
    localparam logic [31:0] TimeoutLast  = 32'(TIMEOUT - 1);
    localparam logic [3:0]  SettleLast   = 4'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [3:0]  settle_q, settle_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [1:0]  fail_code_q, fail_code_d;

    logic [31:0] rom_q [DEPTH];

    // Fetch decode. The subtraction wraps for addresses below ADDR_BASE, which
    // lands them far out of range and so correctly reports a miss.
    logic [31:0]   offset;
    logic [AW-1:0] rom_idx;
    logic          is_halt;
    logic          fetch_hit;
    logic          fetch_miss;

    always_comb begin
        offset     = instr_bus.instr_address - ADDR_BASE;
        rom_idx    = offset[AW+1:2];
        is_halt    = (instr_bus.instr_address == HALT_ADDR);
        fetch_hit  = (offset[1:0] == 2'b00) && ({2'b00, offset[31:2]} < 32'(DEPTH));
        fetch_miss = !fetch_hit && !is_halt;
    end

    assign instr_bus.instr_readdata = (fetch_hit && !is_halt) ? rom_q[rom_idx] : 32'h0;

    // Loads are not gated by clk_enable; the ROM is deliberately left out of reset
    // so a program survives an aborted run.
    always_ff @(posedge clk) begin
        if (load_en && (state_q == StIdle || state_q == StDone)) begin
            rom_q[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        settle_d      = settle_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_code_d   = fail_code_q;

        if (clk_enable) begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d       = StRun;
                        cycle_count_d = 32'd0;
                        settle_d      = 4'd0;
                        done_d        = 1'b0;
                        pass_d        = 1'b0;
                        fail_code_d   = FailNone;
                    end
                end
                StRun: begin
                    // Halt wins over fault, fault wins over timeout.
                    if (is_halt) begin
                        state_d  = StSettle;
                        settle_d = 4'd0;
                    end else if (fetch_miss) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        fail_code_d = FailFetch;
                    end else if (cycle_count_q == TimeoutLast) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        fail_code_d = FailTimeout;
                    end else begin
                        cycle_count_d = cycle_count_q + 32'd1;
                    end
                end
                StSettle: begin
                    if (settle_q == SettleLast) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        if (register_v0 == expected_v0) begin
                            pass_d = 1'b1;
                        end else begin
                            fail_code_d = FailMismatch;
                        end
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cycle_count_q <= 32'd0;
            settle_q      <= 4'd0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_code_q   <= FailNone;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            settle_q      <= settle_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_code_q   <= fail_code_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_prog_rom_monitor.sv
// Bench for prog_rom_monitor: emulates CPU fetch sequences, queues the expected
// result of each run at start and compares when done rises.
module tb_prog_rom_monitor;

    localparam logic [31:0] Base     = 32'hBFC00000;
    localparam logic [31:0] HaltAddr = 32'h00000000;
    localparam int          Depth    = 64;
    localparam int          Timeout  = 40;
    localparam int          Settle   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        start = 1'b0;
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic [31:0] expected_v0 = '0;
    logic [31:0] register_v0 = '0;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [31:0] cycle_count;

    prog_rom_monitor_if bus ();

    prog_rom_monitor #(
        .ADDR_BASE (Base),
        .DEPTH     (Depth),
        .HALT_ADDR (HaltAddr),
        .TIMEOUT   (Timeout),
        .SETTLE    (Settle)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .start       (start),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .expected_v0 (expected_v0),
        .register_v0 (register_v0),
        .instr_bus   (bus),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pass;
        logic [1:0]  code;
        logic [31:0] count;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rom_m [Depth];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    endtask

    function automatic exp_t mk(input string tag, input logic p, input logic [1:0] c,
                                input logic [31:0] n);
        exp_t e;
        e.tag = tag;
        e.pass = p;
        e.code = c;
        e.count = n;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: pops one entry per rising edge of done.
    logic done_prev = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_done", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq({e.tag, "_pass"}, 32'(pass), 32'(e.pass));
                check_eq({e.tag, "_code"}, 32'(fail_code), 32'(e.code));
                check_eq({e.tag, "_count"}, cycle_count, e.count);
            end
        end
        done_prev = done;
    end

    task automatic start_run(input exp_t e);
        sb.push_back(e);
        bus.instr_address = Base;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq({e.tag, "_start_clr"}, 32'(done), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_word, input string tag);
        bus.instr_address = a;
        #1;
        check_eq({tag, "_rd"}, bus.instr_readdata, exp_word);
        step();
    endtask

    task automatic gap(input string tag, input logic [31:0] exp_cc);
        clk_enable = 1'b0;
        repeat (5) step();
        check_eq({tag, "_gap_cc"}, cycle_count, exp_cc);
        check_eq({tag, "_gap_done"}, 32'(done), 32'd0);
        clk_enable = 1'b1;
    endtask

    // Program fetches words 1..6 in RUN (word 0 fetched during the start cycle),
    // then jumps to HALT_ADDR; done must follow exactly Settle enabled edges later.
    task automatic run_prog(input string tag, input logic [31:0] exp_v0, input logic [31:0] v0,
                            input bit gap_run, input bit gap_settle, input bit poke);
        logic ok;
        ok = (exp_v0 == v0);
        expected_v0 = exp_v0;
        register_v0 = v0;
        start_run(mk(tag, ok, ok ? 2'd0 : 2'd1, 32'd6));
        for (int i = 1; i <= 6; i++) begin
            if (gap_run && i == 3) gap(tag, 32'd2);
            if (poke && i == 2) begin
                load_en = 1'b1;
                load_addr = 6'd2;
                load_data = 32'hDEADBEEF;
            end
            fetch(Base + 32'(4 * i), rom_m[i], tag);
            load_en = 1'b0;
        end
        bus.instr_address = HaltAddr;
        #1;
        check_eq({tag, "_halt_rd"}, bus.instr_readdata, 32'h0);
        step();
        if (gap_settle) gap(tag, 32'd6);
        for (int k = 1; k < Settle; k++) begin
            step();
            check_eq({tag, "_early"}, 32'(done), 32'd0);
        end
        step();
        check_eq({tag, "_done_edge"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rom_m[0] = 32'h2408FFFF;  // addiu $t0,$zero,-1
        rom_m[1] = 32'h3109FFFF;  // andi  $t1,$t0,0xffff
        rom_m[2] = 32'h0109102A;  // slt   $v0,$t0,$t1
        rom_m[3] = 32'h24040001;
        rom_m[4] = 32'h00000000;
        rom_m[5] = 32'h00000008;  // jr $0
        rom_m[6] = 32'h00000000;
        for (int i = 7; i < Depth; i++) rom_m[i] = 32'h0;
        bus.instr_address = Base;

        #3;
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pass", 32'(pass), 32'd0);
        check_eq("rst_code", 32'(fail_code), 32'd0);
        check_eq("rst_count", cycle_count, 32'd0);
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < Depth; i++) begin
            load_en = 1'b1;
            load_addr = 6'(i);
            load_data = rom_m[i];
            step();
        end
        load_en = 1'b0;

        run_prog("pass", 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
        bus.instr_address = Base + 32'd8;
        #1;
        check_eq("run_load_ignored", bus.instr_readdata, rom_m[2]);

        run_prog("mism", 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);

        start_run(mk("tmo", 1'b0, 2'd2, 32'd39));
        n = 0;
        while (!done && n < 60) begin
            bus.instr_address = Base + 32'(4 * ((n + 1) % Depth));
            step();
            n++;
        end
        check_eq("tmo_edges", 32'(n), 32'd40);

        start_run(mk("oob", 1'b0, 2'd3, 32'd1));
        fetch(Base + 32'd4, rom_m[1], "oob_w1");
        bus.instr_address = Base + 32'(4 * Depth);
        #1;
        check_eq("oob_rd", bus.instr_readdata, 32'h0);
        step();
        check_eq("oob_done", 32'(done), 32'd1);

        start_run(mk("mis", 1'b0, 2'd3, 32'd0));
        bus.instr_address = Base + 32'd2;
        #1;
        check_eq("mis_rd", bus.instr_readdata, 32'h0);
        step();
        check_eq("mis_done", 32'(done), 32'd1);

        run_prog("gap", 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);

        // Abort a run mid-settle with an asynchronous reset.
        expected_v0 = 32'd1;
        register_v0 = 32'd1;
        start_run(mk("abort", 1'b1, 2'd0, 32'd6));
        for (int i = 1; i <= 6; i++) fetch(Base + 32'(4 * i), rom_m[i], "abort");
        bus.instr_address = HaltAddr;
        step();
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_done", 32'(done), 32'd0);
        check_eq("async_count", cycle_count, 32'd0);
        sb.delete();
        step();
        reset = 1'b1;
        step();
        run_prog("rerun", 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);

        // Load and fetch of the same index in one cycle: fetch sees the old word.
        load_en = 1'b1;
        load_addr = 6'd3;
        load_data = 32'hCAFEF00D;
        bus.instr_address = Base + 32'd12;
        #1;
        check_eq("same_cycle_old", bus.instr_readdata, rom_m[3]);
        step();
        load_en = 1'b0;
        rom_m[3] = 32'hCAFEF00D;
        check_eq("same_cycle_new", bus.instr_readdata, rom_m[3]);

        step();
        step();
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
